// File: rtl/wb_port_arbiter_pkg.sv
// Shared register-file geometry and helpers for the writeback port arbiter.
// Arbitration mode is chosen by WB_ARB_ROUND_ROBIN_EN (see wb_port_arbiter).
package wb_port_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int unsigned MAX_WB_REQ = 8;

  // Next requester index after idx, wrapping at n.
  function automatic int unsigned wrapIncr(input int unsigned idx, input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating first-set picker: scans reqVec starting at startIdx, returns one-hot grant and index.
module wb_rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] reqVec,
  input  logic [IDX_W-1:0]   startIdx,
  output logic [NUM_REQ-1:0] grantVec_c,
  output logic [IDX_W-1:0]   grantIdx_c,
  output logic               grantAny_c
);

  always_comb begin
    int unsigned idx;
    grantVec_c = '0;
    grantIdx_c = '0;
    grantAny_c = 1'b0;
    idx        = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(startIdx) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grantAny_c && reqVec[IDX_W'(idx)]) begin
        grantVec_c[IDX_W'(idx)] = 1'b1;
        grantIdx_c             = IDX_W'(idx);
        grantAny_c             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates NUM_REQ writeback sources onto the single register-file write port.
// WB_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority (index 0 highest).
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = REG_DATA_W,
  parameter int unsigned ADDR_W  = REG_ADDR_W
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_REQ-1:0]        ReqValid,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqReg,
  input  logic [NUM_REQ*DATA_W-1:0] ReqData,
  output logic [NUM_REQ-1:0]        ReqReady,
  output logic [ADDR_W-1:0]         WriteReg1,
  output logic [DATA_W-1:0]         WriteData1,
  output logic                      Write1,
  output logic [(2**ADDR_W)-1:0]    Pending
);

  localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NUM_REGS = 2**ADDR_W;

  logic [ADDR_W-1:0]  reqRegArr  [NUM_REQ];
  logic [DATA_W-1:0]  reqDataArr [NUM_REQ];
  logic [NUM_REQ-1:0] reqLive;
  logic [IDX_W-1:0]   startIdx;
  logic [NUM_REQ-1:0] grantVec_c;
  logic [IDX_W-1:0]   grantIdx_c;
  logic               grantAny_c;
  logic [ADDR_W-1:0]  grantReg;
  logic [DATA_W-1:0]  grantData;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign reqRegArr[i]  = ReqReg[i*ADDR_W +: ADDR_W];
    assign reqDataArr[i] = ReqData[i*DATA_W +: DATA_W];
  end

  // Requests are invisible while reset is held so nothing is granted or pending.
  assign reqLive = ReqValid & {NUM_REQ{RESET}};

  wb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .reqVec     (reqLive),
    .startIdx   (startIdx),
    .grantVec_c (grantVec_c),
    .grantIdx_c (grantIdx_c),
    .grantAny_c (grantAny_c)
  );

  assign ReqReady  = grantVec_c;
  assign grantReg  = reqRegArr[grantIdx_c];
  assign grantData = reqDataArr[grantIdx_c];

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rrPtr;

  // Search start moves just past the last winner.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rrPtr <= '0;
    end else if (grantAny_c) begin
      rrPtr <= IDX_W'(wrapIncr(32'(grantIdx_c), NUM_REQ));
    end
  end

  assign startIdx = rrPtr;
`else
  assign startIdx = '0;
`endif

  // Output stage: a register-0 grant is consumed but never written.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Write1     <= 1'b0;
      WriteReg1  <= '0;
      WriteData1 <= '0;
    end else if (grantAny_c && (grantReg != ADDR_W'(REG_ZERO))) begin
      Write1     <= 1'b1;
      WriteReg1  <= grantReg;
      WriteData1 <= grantData;
    end else begin
      Write1     <= 1'b0;
    end
  end

  assign Pending[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
    logic [NUM_REQ-1:0] hitVec;
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_hit
      assign hitVec[i] = reqLive[i] && (reqRegArr[i] == ADDR_W'(r));
    end
    assign Pending[r] = (|hitVec) || (Write1 && (WriteReg1 == ADDR_W'(r)));
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed + constrained-random bench for wb_port_arbiter with a port-write scoreboard.
// Honours WB_ARB_ROUND_ROBIN_EN for the expected grant order.
module tb_wb_port_arbiter;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [NR-1:0]     ReqValid;
  logic [NR*AW-1:0]  ReqReg;
  logic [NR*DW-1:0]  ReqData;
  logic [NR-1:0]     ReqReady;
  logic [AW-1:0]     WriteReg1;
  logic [DW-1:0]     WriteData1;
  logic              Write1;
  logic [(2**AW)-1:0] Pending;

  wb_port_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ReqValid   (ReqValid),
    .ReqReg     (ReqReg),
    .ReqData    (ReqData),
    .ReqReady   (ReqReady),
    .WriteReg1  (WriteReg1),
    .WriteData1 (WriteData1),
    .Write1     (Write1),
    .Pending    (Pending)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           sbq[$];
  bit            vld  [NR];
  bit            keep [NR];
  logic [AW-1:0] rg   [NR];
  logic [DW-1:0] dt   [NR];
  int            ptr = 0;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Invalid slices carry junk that must be ignored.
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      ReqValid[i]        = vld[i];
      ReqReg[i*AW +: AW] = vld[i] ? rg[i] : AW'($urandom);
      ReqData[i*DW +: DW] = vld[i] ? dt[i] : $urandom;
    end
  endtask

  task automatic setReq(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
    vld[i] = 1'b1;
    rg[i]  = r;
    dt[i]  = d;
  endtask

  // One cycle: entered just after a negedge, leaves at the next negedge.
  task automatic step(input string tag);
    wr_t           cur;
    bit            curv;
    logic [31:0]   expPend;
    logic [NR-1:0] expRdy;
    int            g;
    int            start;
    int            idx;
    drive();
    #1;
    curv = (sbq.size() > 0);
    cur  = '0;
    if (curv) cur = sbq.pop_front();
    chk({tag, ".write1"}, 64'(Write1), 64'(curv));
    if (curv) begin
      chk({tag, ".wreg"},  64'(WriteReg1),  64'(cur.r));
      chk({tag, ".wdata"}, 64'(WriteData1), 64'(cur.d));
    end
    expPend = '0;
    if (curv) expPend[cur.r] = 1'b1;
    for (int i = 0; i < NR; i++) if (vld[i]) expPend[rg[i]] = 1'b1;
    expPend[0] = 1'b0;
    chk({tag, ".pending"}, 64'(Pending), 64'(expPend));
`ifdef WB_ARB_ROUND_ROBIN_EN
    start = ptr;
`else
    start = 0;
`endif
    g = -1;
    for (int k = 0; k < NR; k++) begin
      idx = (start + k) % NR;
      if (g < 0 && vld[idx]) g = idx;
    end
    expRdy = (g >= 0) ? NR'(1 << g) : '0;
    chk({tag, ".ready"}, 64'(ReqReady), 64'(expRdy));
    if (g >= 0) begin
      if (rg[g] != '0) sbq.push_back({rg[g], dt[g]});
      ptr = (g + 1) % NR;
      if (!keep[g]) vld[g] = 1'b0;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      vld[i] = 1'b0; keep[i] = 1'b0; rg[i] = '0; dt[i] = '0;
    end
    // Reset held with all requesters valid (all targeting r0).
    RESET = 1'b0;
    for (int i = 0; i < NR; i++) setReq(i, '0, 32'(i));
    drive();
    #1;
    chk("rst.ready", 64'(ReqReady), 64'(0));
    chk("rst.write1", 64'(Write1), 64'(0));
    chk("rst.wreg", 64'(WriteReg1), 64'(0));
    chk("rst.wdata", 64'(WriteData1), 64'(0));
    chk("rst.pending", 64'(Pending), 64'(0));
    @(negedge CLK);
    @(negedge CLK);
    chk("rst.ready2", 64'(ReqReady), 64'(0));
    RESET = 1'b1;
    ptr = 0;
    for (int i = 0; i < NR; i++) step("rel");
    step("idle0");

    // Single write.
    setReq(1, 5'd7, 32'hDEADBEEF);
    step("single.n");
    step("single.n1");
    step("single.n2");

    // Contention, each drops after acceptance.
    setReq(0, 5'd1, 32'h1111_0001);
    setReq(1, 5'd2, 32'h2222_0002);
    setReq(2, 5'd3, 32'h3333_0003);
    for (int k = 0; k < 4; k++) step("cont");

    // All requesters held valid for six cycles.
    for (int i = 0; i < NR; i++) begin
      setReq(i, AW'(10 + i), 32'hA000_0000 + 32'(i));
      keep[i] = 1'b1;
    end
    for (int k = 0; k < 6; k++) step("hold");
    for (int i = 0; i < NR; i++) begin
      keep[i] = 1'b0; vld[i] = 1'b0;
    end
    step("hold.drain");

    // Register 0 write is consumed silently.
    setReq(0, 5'd0, 32'h1);
    step("r0.n");
    step("r0.n1");

    // Same destination from two requesters.
    setReq(0, 5'd5, 32'hAAAA_AAAA);
    setReq(1, 5'd5, 32'hBBBB_BBBB);
    for (int k = 0; k < 3; k++) step("same");

    // Random traffic without retraction.
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < NR; i++)
        if (!vld[i] && ($urandom_range(0, 1) == 1)) setReq(i, AW'($urandom_range(0, 31)), $urandom);
      step("rand");
    end
    for (int k = 0; k < 4; k++) step("rand.drain");

    // Asynchronous reset while a write is on the port.
    setReq(0, 5'd9, 32'hCAFE_F00D);
    step("mid.grant");
    drive();
    #1;
    chk("mid.write1", 64'(Write1), 64'(1));
    chk("mid.wreg", 64'(WriteReg1), 64'(9));
    #1;
    RESET = 1'b0;
    #1;
    chk("mid.write1_drop", 64'(Write1), 64'(0));
    chk("mid.wreg_clr", 64'(WriteReg1), 64'(0));
    chk("mid.wdata_clr", 64'(WriteData1), 64'(0));
    sbq.delete();
    ptr = 0;
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < NR; i++) setReq(i, AW'(20 + i), 32'h5000_0000 + 32'(i));
    for (int k = 0; k < 4; k++) step("post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
